led_group_ctrl: RTL and testbench

//  Parametrised LED group controller for the board I/O layer: N_GROUPS groups of

---
 rtl/led_group_ctrl.sv | 103 ++++++++++
 tb/tb_led_group_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_group_ctrl
// Purpose  : Switch-to-LED drive per group, with debounced per-group buttons
//            that blank a group (MOMENTARY) or flip its enable (TOGGLE).
// Revision : 1.0  initial release
// ============================================================================
module led_group_ctrl #(
    parameter int N_GROUPS        = 4,
    parameter int GROUP_W         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_GROUPS*GROUP_W-1:0]   sw_i,
    input  logic [N_GROUPS-1:0]           btn_i,
    input  logic                          mode_i,
    output logic [N_GROUPS*GROUP_W-1:0]   led_o,
    output logic [N_GROUPS-1:0]           grp_en_o
);

    localparam int                LED_W      = N_GROUPS * GROUP_W;
    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [LED_W-1:0]    sw_meta_q, sw_s_q;
    logic [N_GROUPS-1:0] btn_meta_q, btn_s_q;
    logic                mode_meta_q, mode_s_q;

    logic [N_GROUPS-1:0] btn_db_q, btn_db_d;
    logic [N_GROUPS-1:0] en_latch_q, en_latch_d;
    logic [LED_W-1:0]    led_q, led_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
            btn_meta_q  <= '0;
            btn_s_q     <= '0;
            mode_meta_q <= 1'b0;
            mode_s_q    <= 1'b0;
        end else begin
            sw_meta_q   <= sw_i;
            sw_s_q      <= sw_meta_q;
            btn_meta_q  <= btn_i;
            btn_s_q     <= btn_meta_q;
            mode_meta_q <= mode_i;
            mode_s_q    <= mode_meta_q;
        end
    end

    generate
        for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_d;

            // Any return to equality clears the count, so only an unbroken run is accepted.
            always_comb begin
                cnt_d = cnt_q;
                db_d  = btn_db_q[g];
                if (btn_s_q[g] == btn_db_q[g]) begin
                    cnt_d = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    db_d  = btn_s_q[g];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign btn_db_d[g]   = db_d;
            assign en_latch_d[g] = (mode_s_q && db_d && !btn_db_q[g]) ? ~en_latch_q[g]
                                                                      : en_latch_q[g];
            assign grp_en_o[g]   = mode_s_q ? en_latch_q[g] : ~btn_db_q[g];
            assign led_d[g*GROUP_W +: GROUP_W] =
                sw_s_q[g*GROUP_W +: GROUP_W] & {GROUP_W{grp_en_o[g]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_q   <= '0;
            en_latch_q <= '1;
            led_q      <= '0;
        end else begin
            btn_db_q   <= btn_db_d;
            en_latch_q <= en_latch_d;
            led_q      <= led_d;
        end
    end

    assign led_o = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_group_ctrl
// Purpose  : Directed stimulus with a cycle-stamped expectation queue and a
//            monitor that compares LED/enable outputs at the stamped cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_group_ctrl;

    localparam int NG = 4;
    localparam int GW = 4;
    localparam int DB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NG*GW-1:0] sw;
    logic [NG-1:0]    btn;
    logic             mode;
    logic [NG*GW-1:0] led;
    logic [NG-1:0]    grp_en;

    led_group_ctrl #(
        .N_GROUPS        (NG),
        .GROUP_W         (GW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_i     (sw),
        .btn_i    (btn),
        .mode_i   (mode),
        .led_o    (led),
        .grp_en_o (grp_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int               q_cyc[$];
    logic [NG*GW-1:0] q_led[$];
    logic [NG-1:0]    q_en[$];
    string            q_nm[$];

    // Expectations are stamped with the posedge count after which they must hold.
    task automatic exp_at(input int dly, input logic [NG*GW-1:0] l,
                          input logic [NG-1:0] e, input string nm);
        q_cyc.push_back(cyc + dly);
        q_led.push_back(l);
        q_en.push_back(e);
        q_nm.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            total++;
            if (q_cyc[0] < cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d missed, now cycle %0d",
                         q_nm[0], q_cyc[0], cyc);
            end else if (led !== q_led[0] || grp_en !== q_en[0]) begin
                bad++;
                $display("FAIL %s @%0d: got led=%h grp_en=%h, expected led=%h grp_en=%h",
                         q_nm[0], cyc, led, grp_en, q_led[0], q_en[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_led.pop_front());
            void'(q_en.pop_front());
            void'(q_nm.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        btn   = '0;
        mode  = 1'b0;

        // Reset and sw->led latency
        @(negedge clk);
        exp_at(1, 16'h0000, 4'hF, "rst_init");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sw = 16'hFFFF;
        exp_at(2, 16'h0000, 4'hF, "sw_lat2");
        exp_at(3, 16'hFFFF, 4'hF, "sw_lat3");
        tick(5);
        rst_n = 1'b0;
        exp_at(1, 16'h0000, 4'hF, "rst_mid");
        tick(2);
        rst_n = 1'b1;
        exp_at(2, 16'h0000, 4'hF, "rst_rel2");
        exp_at(3, 16'hFFFF, 4'hF, "rst_rel3");
        tick(5);

        // MOMENTARY press and release on group 1
        btn = 4'b0010;
        exp_at(5, 16'hFFFF, 4'hF, "mom_pre");
        exp_at(6, 16'hFFFF, 4'hD, "mom_db");
        exp_at(7, 16'hFF0F, 4'hD, "mom_led");
        tick(10);
        btn = 4'b0000;
        exp_at(5, 16'hFF0F, 4'hD, "mom_rel_pre");
        exp_at(6, 16'hFF0F, 4'hF, "mom_rel_db");
        exp_at(7, 16'hFFFF, 4'hF, "mom_rel_led");
        tick(10);

        // Bounce on group 0, then a 3-cycle pulse
        for (int k = 1; k <= 6; k++) exp_at(4 * k, 16'hFFFF, 4'hF, "bounce");
        for (int k = 0; k < 5; k++) begin
            btn[0] = 1'b1;
            tick(2);
            btn[0] = 1'b0;
            tick(2);
        end
        tick(6);
        btn[0] = 1'b1;
        for (int k = 4; k <= 10; k += 2) exp_at(k, 16'hFFFF, 4'hF, "pulse3");
        tick(3);
        btn[0] = 1'b0;
        tick(9);

        // TOGGLE on group 3, long hold, second press
        mode = 1'b1;
        exp_at(3, 16'hFFFF, 4'hF, "tog_mode");
        tick(4);
        btn = 4'b1000;
        exp_at(5,   16'hFFFF, 4'hF, "tog_pre");
        exp_at(6,   16'hFFFF, 4'h7, "tog_en");
        exp_at(7,   16'h0FFF, 4'h7, "tog_led");
        exp_at(50,  16'h0FFF, 4'h7, "tog_hold50");
        exp_at(100, 16'h0FFF, 4'h7, "tog_hold100");
        tick(100);
        btn = 4'b0000;
        exp_at(10, 16'h0FFF, 4'h7, "tog_release");
        tick(12);
        btn = 4'b1000;
        exp_at(6, 16'h0FFF, 4'hF, "tog2_en");
        exp_at(7, 16'hFFFF, 4'hF, "tog2_led");
        tick(10);
        btn = 4'b0000;
        tick(10);

        // Simultaneous toggles, then mode round trip
        btn = 4'b0101;
        exp_at(5, 16'hFFFF, 4'hF, "sim_pre");
        exp_at(6, 16'hFFFF, 4'hA, "sim_en");
        exp_at(7, 16'hF0F0, 4'hA, "sim_led");
        tick(10);
        btn = 4'b0000;
        tick(10);
        mode = 1'b0;
        exp_at(1, 16'hF0F0, 4'hA, "mode0_lat1");
        exp_at(2, 16'hF0F0, 4'hF, "mode0_en");
        exp_at(3, 16'hFFFF, 4'hF, "mode0_led");
        tick(5);
        mode = 1'b1;
        exp_at(2, 16'hFFFF, 4'hA, "mode1_en");
        exp_at(3, 16'hF0F0, 4'hA, "mode1_led");
        tick(5);

        // Reach enable 4'h7, then reset mid-debounce with btn[1] held
        btn = 4'b1101;
        exp_at(6, 16'hF0F0, 4'h7, "set7_en");
        exp_at(7, 16'h0FFF, 4'h7, "set7_led");
        tick(10);
        btn = 4'b0000;
        tick(10);
        btn = 4'b0010;
        tick(4);
        rst_n = 1'b0;
        exp_at(1, 16'h0000, 4'hF, "rst_op");
        tick(2);
        rst_n = 1'b1;
        exp_at(2,  16'h0000, 4'hF, "rst_op_rel2");
        exp_at(3,  16'hFFFF, 4'hF, "rst_op_rel3");
        exp_at(5,  16'hFFFF, 4'hF, "rst_op_pre");
        exp_at(6,  16'hFFFF, 4'hD, "rst_op_tog");
        exp_at(7,  16'hFF0F, 4'hD, "rst_op_led");
        exp_at(27, 16'hFF0F, 4'hD, "rst_op_hold");
        tick(30);
        btn = 4'b0000;
        tick(5);

        while (q_cyc.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: check for cycle %0d never performed", q_nm[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_led.pop_front());
            void'(q_en.pop_front());
            void'(q_nm.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
